row_ss_adc_ctrl: RTL

//  Parametrised single-slope row ADC controller for one pixel row.
//  - Runs one ramp conversion per start request and drives ramp_en to the analog ramp generator.
//  - Latches the shared counter into each pixel's register on that pixel's first comparator rising edge.
//  - Saturates pixels that never trip, then streams the row out over a valid/ready port.
//  - Sits between the per-column comparators and the row readout / frame buffer logic.

---
 rtl/adc_pkg.sv | 27 ++
 rtl/row_adc_pix_cell.sv | 69 ++++++
 rtl/row_ss_adc_ctrl.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/adc_pkg.sv
// Shared types and Gray/binary helpers for the single-slope row ADC controller.
// The helpers work on a wide word; callers zero-extend and truncate to CNT_W.
package adc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        READOUT
    } adc_state_e;

    localparam int unsigned MaxCntW = 32;

    function automatic logic [MaxCntW-1:0] bin2gray(input logic [MaxCntW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [MaxCntW-1:0] gray2bin(input logic [MaxCntW-1:0] g);
        logic [MaxCntW-1:0] b;
        b = g;
        for (int i = 1; i < int'(MaxCntW); i++) begin
            b = b ^ (g >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/row_adc_pix_cell.sv
// Per-column capture cell: latches the shared count on the first comparator rising edge
// of a conversion, or the saturation code if the column never trips.
module row_adc_pix_cell
    import adc_pkg::*;
#(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear_i,
    input  logic             en_i,
    input  logic             saturate_i,
    input  logic             comp_i,
    input  logic [CNT_W-1:0] count_i,
    input  logic [CNT_W-1:0] sat_val_i,
    output logic [CNT_W-1:0] value_o,
    output logic             miss_o
);

    logic             comp_prev_q, comp_prev_d;
    logic             captured_q, captured_d;
    logic             miss_q, miss_d;
    logic [CNT_W-1:0] value_q, value_d;
    logic             trip;

    assign trip = en_i && comp_i && !comp_prev_q && !captured_q;

    always_comb begin
        comp_prev_d = comp_prev_q;
        captured_d  = captured_q;
        miss_d      = miss_q;
        value_d     = value_q;
        if (clear_i) begin
            // The old sample is kept until this conversion overwrites it.
            comp_prev_d = 1'b0;
            captured_d  = 1'b0;
            miss_d      = 1'b0;
        end else begin
            if (en_i) begin
                comp_prev_d = comp_i;
            end
            if (trip) begin
                value_d    = count_i;
                captured_d = 1'b1;
            end else if (saturate_i && !captured_q) begin
                value_d = sat_val_i;
                miss_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            comp_prev_q <= 1'b0;
            captured_q  <= 1'b0;
            miss_q      <= 1'b0;
            value_q     <= '0;
        end else begin
            comp_prev_q <= comp_prev_d;
            captured_q  <= captured_d;
            miss_q      <= miss_d;
            value_q     <= value_d;
        end
    end

    assign value_o = value_q;
    assign miss_o  = miss_q;

endmodule

// File: rtl/row_ss_adc_ctrl.sv
// Single-slope row ADC controller: ramp conversion, per-pixel capture, valid/ready readout.
// Define ADC_GRAY_CNT_EN to run the shared counter and stored samples in Gray code.
module row_ss_adc_ctrl
    import adc_pkg::*;
#(
    parameter  int unsigned NUM_PIXELS = 11,
    parameter  int unsigned CNT_W      = 8,
    localparam int unsigned IDX_W      = $clog2(NUM_PIXELS)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    input  logic                             abort,
    input  logic [NUM_PIXELS-1:0]            comp,
    output logic                             ramp_en,
    output logic                             busy,
    output logic [NUM_PIXELS-1:0][CNT_W-1:0] stored_values,
    output logic                             rd_valid,
    input  logic                             rd_ready,
    output logic [IDX_W-1:0]                 rd_idx,
    output logic [CNT_W-1:0]                 rd_data,
    output logic                             rd_miss,
    output logic                             done
);

    localparam logic [CNT_W-1:0] MaxCnt  = '1;
    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_PIXELS - 1);

    adc_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             done_q, done_d;

    logic [CNT_W-1:0]      cnt_bin;
    logic [CNT_W-1:0]      cnt_bin_inc;
    logic [CNT_W-1:0]      cnt_inc;
    logic [CNT_W-1:0]      sat_val;
    logic [CNT_W-1:0]      sel_value;
    logic [NUM_PIXELS-1:0] miss_vec;
    logic                  cell_clear;
    logic                  cell_en;
    logic                  cell_saturate;
    logic                  xfer;

    assign cnt_bin_inc = cnt_bin + CNT_W'(1);

`ifdef ADC_GRAY_CNT_EN
    assign cnt_bin = CNT_W'(gray2bin(MaxCntW'(cnt_q)));
    assign cnt_inc = CNT_W'(bin2gray(MaxCntW'(cnt_bin_inc)));
    assign sat_val = CNT_W'(bin2gray(MaxCntW'(MaxCnt)));
    assign rd_data = CNT_W'(gray2bin(MaxCntW'(sel_value)));
`else
    assign cnt_bin = cnt_q;
    assign cnt_inc = cnt_bin_inc;
    assign sat_val = MaxCnt;
    assign rd_data = sel_value;
`endif

    // Outputs decoded from registered state so an async reset drops them immediately.
    assign ramp_en   = (state_q == CONVERT);
    assign busy      = (state_q != IDLE);
    assign rd_valid  = (state_q == READOUT) && !abort;
    assign rd_idx    = idx_q;
    assign sel_value = stored_values[idx_q];
    assign rd_miss   = miss_vec[idx_q];
    assign done      = done_q;
    assign xfer      = rd_valid && rd_ready;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        idx_d         = idx_q;
        done_d        = 1'b0;
        cell_clear    = 1'b0;
        cell_en       = 1'b0;
        cell_saturate = 1'b0;
        if (abort) begin
            state_d = IDLE;
            cnt_d   = '0;
            idx_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d    = CONVERT;
                        cnt_d      = '0;
                        cell_clear = 1'b1;
                    end
                end
                CONVERT: begin
                    cell_en = 1'b1;
                    if (cnt_bin == MaxCnt) begin
                        state_d       = READOUT;
                        cnt_d         = '0;
                        idx_d         = '0;
                        cell_saturate = 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                READOUT: begin
                    if (xfer) begin
                        if (idx_q == LastIdx) begin
                            state_d = IDLE;
                            idx_d   = '0;
                            done_d  = 1'b1;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
        end
    end

    for (genvar i = 0; i < NUM_PIXELS; i++) begin : g_pix
        row_adc_pix_cell #(
            .CNT_W(CNT_W)
        ) u_cell (
            .clk       (clk),
            .rst_n     (rst_n),
            .clear_i   (cell_clear),
            .en_i      (cell_en),
            .saturate_i(cell_saturate),
            .comp_i    (comp[i]),
            .count_i   (cnt_q),
            .sat_val_i (sat_val),
            .value_o   (stored_values[i]),
            .miss_o    (miss_vec[i])
        );
    end

endmodule
